// File: rtl/dma_pkg.sv
// Shared definitions for the ports-side DMA initiators.
//   DMA_AW        : DMA address width
//   DMA_CW        : width of FIFO/outstanding counters (covers depths up to 8)
//   DMA_REG_*     : register indices on regsel
//   send_state_t  : MP3 send FSM states
package dma_pkg;

    localparam int DMA_AW = 21;
    localparam int DMA_CW = 4;

    localparam logic [1:0] DMA_REG_ADDR0 = 2'd0;
    localparam logic [1:0] DMA_REG_ADDR1 = 2'd1;
    localparam logic [1:0] DMA_REG_ADDR2 = 2'd2;
    localparam logic [1:0] DMA_REG_CTRL  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD,
        WAITRDY
    } send_state_t;

endpackage

// File: rtl/dma_mp3_fifo.sv
// Byte FIFO between the DMA read returns and the MP3 data SPI.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : write a byte (ignored when full)
//   pop           : drop the head byte (ignored when empty)
//   flush         : empty the FIFO; wins over push/pop in the same cycle
//   rdata         : head byte (valid when cnt != 0)
//   cnt           : number of bytes held
module dma_mp3_fifo
    import dma_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic [DMA_CW-1:0] cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [DMA_CW-1:0] FULL = DMA_CW'(DEPTH);

    logic [DEPTH-1:0][7:0] mem;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic                  do_push, do_pop;

    assign do_push = push && (cnt != FULL);
    assign do_pop  = pop && (cnt != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dma_mp3.sv
// Memory-to-MP3 streaming DMA initiator.
// Reads a programmed RAM block over the dma_req/dma_ack/dma_end handshake,
// buffers the bytes and feeds them one at a time to the MP3 data SPI.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   module_select, write_strobe,
//   regsel, din, dout                 : register access (dout combinational)
//   dma_req/ack/end, dma_rnw, dma_rd,
//   dma_wd, dma_addr                  : DMA read initiator side
//   md_din, md_start, md_rdy          : MP3 data SPI
//   mp3_req                           : VS10xx DREQ
// Build option: DMA_MP3_DREQ_EN makes the send FSM wait for mp3_req=1
// before issuing a byte; without it mp3_req is status-only.
module dma_mp3
    import dma_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              module_select,
    input  logic              write_strobe,
    input  logic [1:0]        regsel,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic              dma_req,
    input  logic              dma_ack,
    input  logic              dma_end,
    output logic              dma_rnw,
    input  logic [7:0]        dma_rd,
    output logic [7:0]        dma_wd,
    output logic [DMA_AW-1:0] dma_addr,
    output logic [7:0]        md_din,
    output logic              md_start,
    input  logic              md_rdy,
    input  logic              mp3_req
);

    localparam logic [DMA_CW:0] DEPTH_W = (DMA_CW + 1)'(FIFO_DEPTH);

    logic [DMA_AW-1:0] addr;
    logic [8:0]        req_left, send_left, count_val;
    logic [DMA_CW-1:0] outstanding, fifo_cnt;
    logic [7:0]        fifo_head;
    send_state_t       state, state_nxt;
    logic              busy, ctrl_wr, start, abort, push, go, dreq_ok;

`ifdef DMA_MP3_DREQ_EN
    assign dreq_ok = mp3_req;
`else
    assign dreq_ok = 1'b1;
`endif

    assign ctrl_wr   = module_select && write_strobe && (regsel == DMA_REG_CTRL);
    assign start     = ctrl_wr && !busy;
    assign abort     = ctrl_wr && busy;
    assign count_val = (din == 8'd0) ? 9'd256 : {1'b0, din};

    // send_left always equals fifo_cnt + outstanding + req_left during a
    // transfer, so it also covers bytes still in flight.  After an abort it
    // is zero while late dma_end data drains, which is what discards it.
    assign busy = (send_left != '0) || (state != IDLE) || (outstanding != '0);
    assign push = dma_end && (send_left != '0);

    // Never request more than the FIFO can absorb, counting bytes in flight.
    assign dma_req  = (req_left != '0) &&
                      (({1'b0, outstanding} + {1'b0, fifo_cnt}) < DEPTH_W);
    assign dma_addr = addr;
    assign dma_rnw  = 1'b1;
    assign dma_wd   = 8'h00;

    dma_mp3_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (go),
        .flush (abort),
        .wdata (dma_rd),
        .rdata (fifo_head),
        .cnt   (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            addr        <= '0;
            req_left    <= '0;
            send_left   <= '0;
            outstanding <= '0;
            md_din      <= 8'h00;
        end else begin
            if (module_select && write_strobe && !busy) begin
                unique case (regsel)
                    DMA_REG_ADDR0: addr[7:0]   <= din;
                    DMA_REG_ADDR1: addr[15:8]  <= din;
                    DMA_REG_ADDR2: addr[20:16] <= din[4:0];
                    default:       ;
                endcase
            end
            if (dma_ack)
                addr <= addr + 1'b1;

            if (start) begin
                req_left  <= count_val;
                send_left <= count_val;
            end else if (abort) begin
                req_left  <= '0;
                send_left <= '0;
            end else begin
                if (dma_ack) req_left  <= req_left - 1'b1;
                if (go)      send_left <= send_left - 1'b1;
            end

            // An ack in the abort cycle still counts so its dma_end is drained.
            outstanding <= outstanding + DMA_CW'(dma_ack) - DMA_CW'(dma_end);

            // The byte is taken from the FIFO on the edge into ISSUE so that
            // md_din is already valid while md_start is high.
            if (go)
                md_din <= fifo_head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        unique case (state)
            IDLE: begin
                // An abort in this cycle must not launch a byte it is flushing.
                if ((fifo_cnt != '0) && md_rdy && dreq_ok && !abort) begin
                    state_nxt = ISSUE;
                    go        = 1'b1;
                end
            end
            ISSUE:   state_nxt = HOLD;
            HOLD:    state_nxt = WAITRDY;   // SPI may not have dropped md_rdy yet
            WAITRDY: if (md_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign md_start = (state == ISSUE);

    always_comb begin
        dout = 8'h00;
        unique case (regsel)
            DMA_REG_ADDR0: dout = addr[7:0];
            DMA_REG_ADDR1: dout = addr[15:8];
            DMA_REG_ADDR2: dout = {3'b000, addr[20:16]};
            DMA_REG_CTRL:  dout = {busy, mp3_req, 3'b000, fifo_cnt[2:0]};
            default:       dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_dma_mp3.sv
module tb_dma_mp3;

    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, module_select, write_strobe;
    logic [1:0]  regsel;
    logic [7:0]  din, dout;
    logic        dma_req, dma_ack, dma_end, dma_rnw;
    logic [7:0]  dma_rd, dma_wd;
    logic [20:0] dma_addr;
    logic [7:0]  md_din;
    logic        md_start, md_rdy, mp3_req;

    always #5 clk = ~clk;

    dma_mp3 #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .module_select(module_select), .write_strobe(write_strobe),
        .regsel(regsel), .din(din), .dout(dout),
        .dma_req(dma_req), .dma_ack(dma_ack), .dma_end(dma_end), .dma_rnw(dma_rnw),
        .dma_rd(dma_rd), .dma_wd(dma_wd), .dma_addr(dma_addr),
        .md_din(md_din), .md_start(md_start), .md_rdy(md_rdy), .mp3_req(mp3_req)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: request addresses and SPI bytes in the order they must appear
    logic [20:0] exp_addr[$];
    logic [7:0]  exp_data[$];

    typedef struct { int due; logic [7:0] data; } pend_t;
    pend_t pend[$];
    pend_t pe;

    // responder / SPI knobs
    int   lat = 2, ack_pct = 100, max_pend = 64, spi_len = 3;
    bit   spi_rand = 0, use_seq = 0, rand_dreq = 0;
    logic [7:0] seq_next = 8'hA0;
    int   spi_cnt = 0;

    int n_ack = 0, n_end = 0, n_start = 0, inv_err = 0;
    bit prev_start = 0;

    // memory image seen by the responder
    function automatic logic [7:0] mem_byte(input logic [20:0] a);
        return a[7:0] ^ {a[15:13], a[20:16]} ^ 8'h3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // dma_access responder: acks while dma_req, returns data lat cycles later, in order
    initial begin
        dma_ack = 0; dma_end = 0; dma_rd = 0;
        forever begin
            @(posedge clk); #2;
            dma_ack = 0; dma_end = 0;
            if (rst) pend.delete();
            else begin
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    dma_end = 1; dma_rd = pend[0].data;
                    void'(pend.pop_front());
                    n_end++;
                end
                if (dma_req && pend.size() < max_pend && $urandom_range(99) < ack_pct) begin
                    dma_ack = 1;
                    pe.due  = cyc + lat;
                    pe.data = use_seq ? seq_next : mem_byte(dma_addr);
                    if (use_seq) seq_next = seq_next + 8'd1;
                    pend.push_back(pe);
                    n_ack++;
                end
            end
        end
    end

    // SPI model: md_rdy low for a few cycles after each start
    initial begin
        md_rdy = 1;
        forever begin
            @(posedge clk); #2;
            if (md_start) spi_cnt = spi_rand ? int'($urandom_range(0, 5)) : spi_len;
            else if (spi_cnt > 0) begin md_rdy = 0; spi_cnt--; end
            else md_rdy = 1;
        end
    end

    // monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (dma_ack) begin
                if (exp_addr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dma_addr: unexpected ack at 0x%0h, nothing expected", dma_addr);
                end else chk("dma_addr", 32'(dma_addr), 32'(exp_addr.pop_front()));
            end
            if (md_start) begin
                n_start++;
                chk("md_rdy_at_start", 32'(md_rdy), 32'(1));
                chk("md_start_gap", 32'(prev_start), 32'(0));
                if (exp_data.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL md_din: unexpected md_start with 0x%0h, nothing expected", md_din);
                end else chk("md_din", 32'(md_din), 32'(exp_data.pop_front()));
            end
            if (dut.fifo_cnt == 4'(FIFO_DEPTH) && dut.outstanding != 0) inv_err++;
        end
        prev_start = md_start && !rst;
    end

    task automatic wr(input logic [1:0] r, input logic [7:0] d);
        regsel = r; din = d; module_select = 1; write_strobe = 1;
        @(posedge clk); #1;
        write_strobe = 0; module_select = 0;
    endtask

    task automatic rd(input logic [1:0] r, output logic [7:0] d);
        regsel = r; module_select = 1;
        #1 d = dout;
    endtask

    task automatic program_xfer(input logic [20:0] base, input int cnt);
        logic [20:0] a;
        for (int i = 0; i < cnt; i++) begin
            a = base + 21'(i);
            exp_addr.push_back(a);
            exp_data.push_back(use_seq ? 8'(8'hA0 + i) : mem_byte(a));
        end
        wr(2'd0, base[7:0]);
        wr(2'd1, base[15:8]);
        wr(2'd2, {3'b101, base[20:16]});   // upper bits must be ignored
        wr(2'd3, (cnt == 256) ? 8'd0 : 8'(cnt));
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        logic [7:0] s;
        int n;
        n = 0;
        forever begin
            @(posedge clk); #1;
            if (rand_dreq) mp3_req = ($urandom_range(3) != 0);
            rd(2'd3, s);
            if (!s[7]) break;
            n++;
            if (n >= max_cyc) begin
                checks++; errors++;
                $display("FAIL %s_timeout: busy still 1 after %0d cycles", name, max_cyc);
                break;
            end
        end
    endtask

    task automatic check_done(input string name, input int n_exp, input int ack0, input int st0);
        chk({name, "_acks"},   32'(n_ack - ack0),     32'(n_exp));
        chk({name, "_starts"}, 32'(n_start - st0),    32'(n_exp));
        chk({name, "_addr_q"}, 32'(exp_addr.size()),  32'(0));
        chk({name, "_data_q"}, 32'(exp_data.size()),  32'(0));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  s;
        logic [20:0] base;
        int ack0, st0, end0, cnt;

        rst = 1; module_select = 0; write_strobe = 0; regsel = 0; din = 0; mp3_req = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // reset state
        chk("rst_dma_req",  32'(dma_req),  32'(0));
        chk("rst_dma_rnw",  32'(dma_rnw),  32'(1));
        chk("rst_dma_wd",   32'(dma_wd),   32'(0));
        chk("rst_dma_addr", 32'(dma_addr), 32'(0));
        chk("rst_md_start", 32'(md_start), 32'(0));
        chk("rst_md_din",   32'(md_din),   32'(0));
        rd(2'd3, s);
        chk("rst_status", 32'(s), 32'(0));
        mp3_req = 1;

        // basic transfer across a 64K boundary
        @(posedge clk); #1;
        use_seq = 1; seq_next = 8'hA0; lat = 2; ack_pct = 100; spi_len = 3;
        ack0 = n_ack; st0 = n_start;
        program_xfer(21'h01FFFE, 4);
        wait_idle("basic", 500);
        check_done("basic", 4, ack0, st0);
        use_seq = 0;

        // address wrap at the top of the 2 MB space
        @(posedge clk); #1;
        ack0 = n_ack; st0 = n_start;
        program_xfer(21'h1FFFFF, 2);
        wait_idle("wrap", 500);
        check_done("wrap", 2, ack0, st0);
        rd(2'd0, s); chk("wrap_reg0", 32'(s), 32'h01);
        rd(2'd1, s); chk("wrap_reg1", 32'(s), 32'h00);
        rd(2'd2, s); chk("wrap_reg2", 32'(s), 32'h00);

        // count 0 means 256
        @(posedge clk); #1;
        base = 21'($urandom); lat = 3; ack_pct = 70; spi_len = 2;
        ack0 = n_ack; st0 = n_start;
        program_xfer(base, 256);
        wait_idle("count0", 20000);
        check_done("count0", 256, ack0, st0);

        // DREQ stall
        @(posedge clk); #1;
        lat = 2; ack_pct = 100; mp3_req = 0;
        ack0 = n_ack; st0 = n_start;
        program_xfer(21'($urandom), 8);
        repeat (30) @(posedge clk);
        #1;
`ifdef DMA_MP3_DREQ_EN
        chk("stall_acks",    32'(n_ack - ack0),   32'(4));
        chk("stall_starts",  32'(n_start - st0),  32'(0));
        chk("stall_dma_req", 32'(dma_req),        32'(0));
        rd(2'd3, s);
        chk("stall_status",  32'(s), 32'h84);
`else
        rd(2'd3, s);
        chk("stall_status_dreq", 32'(s[6]), 32'(0));
`endif
        @(posedge clk); #1;
        mp3_req = 1;
        wait_idle("stall", 1000);
        check_done("stall", 8, ack0, st0);

        // abort with two requests outstanding
        @(posedge clk); #1;
        lat = 6; max_pend = 2; ack_pct = 100; spi_len = 2;
        st0 = n_start;
        program_xfer(21'($urandom), 10);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_pend_before", 32'(pend.size()), 32'(2));
        chk("abort_req_before",  32'(dma_req),     32'(1));
        end0 = n_end;
        wr(2'd3, 8'h00);
        exp_addr.delete(); exp_data.delete();
        chk("abort_req_drop", 32'(dma_req), 32'(0));
        rd(2'd3, s);
        chk("abort_busy_held", 32'(s[7]), 32'(1));
        wait_idle("abort", 200);
        chk("abort_pend_drained", 32'(pend.size()),  32'(0));
        chk("abort_ends",         32'(n_end - end0), 32'(2));
        chk("abort_starts",       32'(n_start - st0), 32'(0));
        rd(2'd3, s);
        chk("abort_status", 32'(s), 32'h40);
        max_pend = 64;

        // randomized transfers
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            cnt = $urandom_range(1, 40);
            lat = $urandom_range(1, 5); ack_pct = $urandom_range(30, 100);
            spi_rand = 1; rand_dreq = 1;
            ack0 = n_ack; st0 = n_start;
            program_xfer(21'($urandom), cnt);
            wait_idle("rand", 5000);
            rand_dreq = 0; mp3_req = 1;
            check_done("rand", cnt, ack0, st0);
        end
        spi_rand = 0;

        // reset in the middle of a transfer
        @(posedge clk); #1;
        lat = 3; ack_pct = 100;
        program_xfer(21'($urandom), 20);
        repeat (12) @(posedge clk);
        #1;
        rst = 1; mp3_req = 0;
        exp_addr.delete(); exp_data.delete();
        @(posedge clk); #1;
        rst = 0;
        chk("mid_rst_dma_req",  32'(dma_req),  32'(0));
        chk("mid_rst_dma_addr", 32'(dma_addr), 32'(0));
        chk("mid_rst_md_start", 32'(md_start), 32'(0));
        chk("mid_rst_md_din",   32'(md_din),   32'(0));
        rd(2'd3, s);
        chk("mid_rst_status", 32'(s), 32'h00);
        rd(2'd2, s);
        chk("mid_rst_reg2", 32'(s), 32'h00);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_quiet_req", 32'(dma_req), 32'(0));

        chk("fifo_full_invariant", 32'(inv_err), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
